// File: rtl/rx_pkg.sv
// Shared definitions for the receive capture path: capture FSM states and the
// default image geometry agreed with the transmit ROM.
package rx_pkg;

  localparam int RX_DATA_WIDTH = 8;
  localparam int RX_ADDR_WIDTH = 2;

  typedef enum logic {
    CAPTURE = 1'b0,
    FULL    = 1'b1
  } state_t;

  function automatic int depth_of(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/rx_ram_if.sv
// Write handshake and read port of the receive capture buffer.
// master = receiver/checker side, slave = buffer side.
interface rx_ram_if
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_WIDTH,
  parameter int ADDR_WIDTH = RX_ADDR_WIDTH
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  read;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output wr_valid, wr_data, read, rd_addr,
    input  wr_ready, q
  );

  modport slave (
    input  wr_valid, wr_data, read, rd_addr,
    output wr_ready, q
  );
endinterface

// File: rtl/rx_ram_core.sv
// Simple dual-port RAM: synchronous write, registered read-first read.
// Storage is never reset; only the read register clears on rst.
module rx_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the same array gives read-first on a collision.
  always_ff @(posedge clk) begin
    if (rst)     q_reg <= '0;
    else if (re) q_reg <= mem[raddr];
  end

  assign q = q_reg;
endmodule

// File: rtl/rx_ram.sv
// Receive capture buffer: fills RAM from address 0 over valid/ready,
// reports full/done/overflow, and exposes a registered read port.
module rx_ram
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_WIDTH,
  parameter int ADDR_WIDTH = RX_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  rx_ram_if.slave           bus,
  input  logic              clear,
  output logic [ADDR_WIDTH:0] count,
  output logic              full,
  output logic              done,
  output logic              overflow
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  done_reg;
  logic                  overflow_reg;
  logic                  accept;
  logic                  last_word;

  // clear wins over a word offered in the same cycle.
  assign accept    = bus.wr_valid && (state_reg == CAPTURE) && !clear;
  assign last_word = (count_reg == (ADDR_WIDTH+1)'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= CAPTURE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      CAPTURE: if (!clear && accept && last_word) state_next = FULL;
      FULL:    if (clear) state_next = CAPTURE;
      default: state_next = CAPTURE;
    endcase
  end

  always_comb begin
    bus.wr_ready = (state_reg == CAPTURE);
    full         = (state_reg == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg     <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wptr_reg     <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= accept && last_word;
      if (accept) begin
        wptr_reg <= wptr_reg + 1'b1;
        if (count_reg != (ADDR_WIDTH+1)'(DEPTH)) count_reg <= count_reg + 1'b1;
      end
      if (bus.wr_valid && state_reg == FULL) overflow_reg <= 1'b1;
    end
  end

  assign count    = count_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;

  rx_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wptr_reg),
    .wdata (bus.wr_data),
    .re    (bus.read),
    .raddr (bus.rd_addr),
    .q     (bus.q)
  );
endmodule

// File: tb/tb_rx_ram.sv
// Bench for rx_ram: a fill-order model of the buffer checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rx_ram;
  import rx_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [AW:0] count;
  logic        full, done, overflow;

  rx_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rx_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clear    (clear),
    .count    (count),
    .full     (full),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: words land at address = number captured so far; nothing beyond DEPTH.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_count = 0;
  bit            m_ovf = 1'b0;
  bit            m_done = 1'b0;
  logic [DW-1:0] m_q = '0;
  bit            m_q_known = 1'b1;
  bit            started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      started   = 1'b1;
      m_count   = 0;
      m_ovf     = 1'b0;
      m_done    = 1'b0;
      m_q       = '0;
      m_q_known = 1'b1;
    end else begin
      m_done = 1'b0;
      if (bus.read) begin
        m_q       = m_mem[bus.rd_addr];
        m_q_known = m_known[bus.rd_addr];
      end
      if (clear) begin
        m_count = 0;
        m_ovf   = 1'b0;
      end else if (bus.wr_valid) begin
        if (m_count == DEPTH) m_ovf = 1'b1;
        else begin
          m_mem[m_count]   = bus.wr_data;
          m_known[m_count] = 1'b1;
          m_count++;
          if (m_count == DEPTH) m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("count",    32'(count),        32'(m_count));
      chk("full",     32'(full),         32'(m_count == DEPTH));
      chk("wr_ready", 32'(bus.wr_ready), 32'(m_count != DEPTH));
      chk("done",     32'(done),         32'(m_done));
      chk("overflow", 32'(overflow),     32'(m_ovf));
      if (m_q_known) chk("q", 32'(bus.q), 32'(m_q));
      if (done === 1'b1) done_seen++;
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit rd,
                     input logic [AW-1:0] a, input bit clr, input bit r);
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.read     = rd;
    bus.rd_addr  = a;
    clear        = clr;
    rst          = r;
    @(posedge clk);
    #1;
    $display("[TB] rst=%0b clr=%0b v=%0b d=%h rd=%0b a=%0d -> cnt=%0d full=%0b done=%0b ovf=%0b q=%h",
             r, clr, v, d, rd, a, count, full, done, overflow, bus.q);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.read     = 1'b0;
    bus.rd_addr  = '0;
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_q", 32'(bus.q), 32'd0);

    // Fill
    cyc(1, 8'hA5, 0, 0, 0, 0);
    cyc(1, 8'h3C, 0, 0, 0, 0);
    cyc(1, 8'hFF, 0, 0, 0, 0);
    cyc(1, 8'h01, 0, 0, 0, 0);
    chk("fill_done", 32'(done), 32'd1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("done_drop", 32'(done), 32'd0);
    cyc(0, 8'h00, 1, 0, 0, 0); chk("rd0", 32'(bus.q), 32'hA5);
    cyc(0, 8'h00, 1, 1, 0, 0); chk("rd1", 32'(bus.q), 32'h3C);
    cyc(0, 8'h00, 1, 2, 0, 0); chk("rd2", 32'(bus.q), 32'hFF);
    cyc(0, 8'h00, 1, 3, 0, 0); chk("rd3", 32'(bus.q), 32'h01);

    // Backpressure
    for (int i = 0; i < 3; i++) cyc(1, 8'h77, 1, 0, 0, 0);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_mem0", 32'(bus.q), 32'hA5);

    // Clear with a word offered in the same cycle
    cyc(1, 8'h99, 0, 0, 1, 0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_ready", 32'(bus.wr_ready), 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    cyc(0, 8'h00, 1, 0, 0, 0); chk("clr_no99", 32'(bus.q), 32'hA5);
    cyc(1, 8'h42, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0); chk("clr_42", 32'(bus.q), 32'h42);

    // Read-first collision on address 1
    cyc(1, 8'h5A, 1, 1, 0, 0); chk("rf_old", 32'(bus.q), 32'h3C);
    cyc(0, 8'h00, 1, 1, 0, 0); chk("rf_new", 32'(bus.q), 32'h5A);

    // Reset mid-fill (two words captured)
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_q", 32'(bus.q), 32'd0);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    cyc(1, 8'hE7, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0); chk("mr_addr0", 32'(bus.q), 32'hE7);

    // Gapped input
    cyc(0, 8'h00, 0, 0, 1, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(i % 2 == 0, 8'(8'h11 * (i / 2 + 1)), 0, 0, 0, 0);
      chk("gap_count", 32'(count), 32'(i / 2 + 1));
    end
    cyc(0, 8'h00, 1, 3, 0, 0);
    chk("gap_last", 32'(bus.q), 32'h44);
    chk("gap_done_once", 32'(done_seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
